// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and the circular priority-pick helper for rr_arbiter16.
package rr_arb_pkg;
  localparam int NREQ = 16;
  localparam int IDXW = 4;
  localparam int TOW  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index of the first set bit of r when scanning p, p+1, ... modulo NREQ.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDXW-1:0] p);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDXW-1:0]   off;
    dbl = {r, r} >> p;
    rot = dbl[NREQ-1:0];
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDXW'(i);
    end
    return p + off;
  endfunction
endpackage

// File: rtl/onehot_enc16.sv
// Combinational 16-to-4 one-hot to binary encoder; output forced to 0 when en is low.
module onehot_enc16
  import rr_arb_pkg::*;
(
  input  logic            en,
  input  logic [NREQ-1:0] onehot,
  output logic [IDXW-1:0] idx
);
  always_comb begin
    idx = '0;
    if (en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (onehot[i]) idx = idx | IDXW'(i);
      end
    end
  end
endmodule

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter, grant held until done or request drop; one cycle req->grant and release->clear.
// Defining RR_ARB_TIMEOUT_EN adds a forced release after TIMEOUT grant cycles.
module rr_arbiter16
  import rr_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);
  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic            vld_nxt;
  logic [IDXW-1:0] sel;
  logic            rel;
  logic            to_hit;

  assign sel = rr_pick(req, ptr);

`ifdef RR_ARB_TIMEOUT_EN
  logic [TOW-1:0] cnt, cnt_nxt;

  assign to_hit  = (cnt == TOW'(TIMEOUT - 1));
  // done and a dropped request are ordinary releases, so they suppress the pulse.
  assign timeout = (state == GRANT) && to_hit && !done && req[gnt_idx];
  assign cnt_nxt = ((state == GRANT) && !rel) ? cnt + TOW'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end
`else
  logic [TOW-1:0] unused_timeout_param;

  assign unused_timeout_param = TOW'(TIMEOUT);
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    vld_nxt   = gnt_valid;
    ptr_nxt   = ptr;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt   = NREQ'(1) << sel;
          vld_nxt   = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        rel = done || !req[gnt_idx] || to_hit;
        if (rel) begin
          gnt_nxt   = '0;
          vld_nxt   = 1'b0;
          ptr_nxt   = gnt_idx + IDXW'(1);
          state_nxt = IDLE;
        end
      end
    endcase
  end

  onehot_enc16 u_enc (
    .en     (vld_nxt),
    .onehot (gnt_nxt),
    .idx    (idx_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= vld_nxt;
    end
  end
endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: vector table plus hand-written reset and timeout sequences.
module tb_rr_arbiter16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  rr_arbiter16 #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // to is the timeout level during the cycle; vld/idx are the outputs after the edge.
  typedef struct {
    string       name;
    logic [15:0] req;
    logic        done;
    logic        vld;
    logic [3:0]  idx;
    logic        to;
  } vec_t;

  vec_t tab[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string name, logic [15:0] r, logic d, logic v, logic [3:0] i, logic t);
    vec_t x;
    x.name = name; x.req = r; x.done = d; x.vld = v; x.idx = i; x.to = t;
    return x;
  endfunction

  function automatic logic [15:0] exp_gnt(vec_t e);
    return e.vld ? (16'h0001 << e.idx) : 16'h0000;
  endfunction

  task automatic step(input vec_t v);
    vec_t e;
    logic to_pre;
    @(negedge clk);
    req  = v.req;
    done = v.done;
    sb.push_back(v);
    #1 to_pre = timeout;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (to_pre !== e.to || gnt !== exp_gnt(e) || gnt_idx !== e.idx || gnt_valid !== e.vld) begin
      n_bad++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, required gnt=%h idx=%0d vld=%b to=%b",
               e.name, gnt, gnt_idx, gnt_valid, to_pre, exp_gnt(e), e.idx, e.vld, e.to);
    end
  endtask

  task automatic check_zero(input string name);
    n_vec++;
    if (gnt !== 16'h0 || gnt_idx !== 4'h0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, required all zero",
               name, gnt, gnt_idx, gnt_valid, timeout);
    end
  endtask

  // Async reset between clock edges, released after one more rising edge with new_req applied.
  task automatic pulse_reset(input string name, input logic [15:0] new_req);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(name);
    req  = new_req;
    done = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 16'h0;
    done  = 1'b0;
    #3 check_zero("reset_state");
    #4 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) tab.push_back(mk("idle_noreq", 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0));
    tab.push_back(mk("idle_done_ignored", 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0));
    tab.push_back(mk("b_grant0",       16'h8001, 1'b0, 1'b1, 4'd0,  1'b0));
    tab.push_back(mk("b_rel0",         16'h8001, 1'b1, 1'b0, 4'd0,  1'b0));
    tab.push_back(mk("b_grant15",      16'h8001, 1'b0, 1'b1, 4'd15, 1'b0));
    tab.push_back(mk("b_rel15",        16'h8001, 1'b1, 1'b0, 4'd0,  1'b0));
    tab.push_back(mk("b_wrap_grant0",  16'h8001, 1'b0, 1'b1, 4'd0,  1'b0));
    tab.push_back(mk("b_rel0b",        16'h8001, 1'b1, 1'b0, 4'd0,  1'b0));
    tab.push_back(mk("d_grant5",       16'h0020, 1'b0, 1'b1, 4'd5,  1'b0));
    tab.push_back(mk("d_hold5",        16'h0FFF, 1'b0, 1'b1, 4'd5,  1'b0));
    tab.push_back(mk("d_drop5",        16'h0200, 1'b0, 1'b0, 4'd0,  1'b0));
    tab.push_back(mk("d_grant9_ptr6",  16'h0210, 1'b0, 1'b1, 4'd9,  1'b0));
    tab.push_back(mk("d_rel9",         16'h0210, 1'b1, 1'b0, 4'd0,  1'b0));
    tab.push_back(mk("e_grant7",       16'h0080, 1'b0, 1'b1, 4'd7,  1'b0));
    tab.push_back(mk("e_hold7",        16'h0080, 1'b0, 1'b1, 4'd7,  1'b0));
    foreach (tab[i]) step(tab[i]);

    pulse_reset("midgrant_async_reset", 16'h0088);
    step(mk("e_after_reset_grant3", 16'h0088, 1'b0, 1'b1, 4'd3, 1'b0));
    step(mk("e_rel3",               16'h0088, 1'b1, 1'b0, 4'd0, 1'b0));

    pulse_reset("reset_before_sweep", 16'h0000);
    for (int k = 0; k <= 16; k++) begin
      step(mk("sweep_grant", 16'hFFFF, 1'b0, 1'b1, 4'(k % 16), 1'b0));
      step(mk("sweep_idle",  16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0));
    end
    step(mk("idle_done_with_req", 16'h0008, 1'b1, 1'b1, 4'd3, 1'b0));
    step(mk("rel3_done",          16'h0008, 1'b1, 1'b0, 4'd0, 1'b0));

    pulse_reset("reset_before_timeout", 16'h0000);
    step(mk("to_grant2", 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0));
`ifdef RR_ARB_TIMEOUT_EN
    for (int c = 0; c < 3; c++) step(mk("to_hold", 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0));
    step(mk("to_fire",          16'h0004, 1'b0, 1'b0, 4'd0, 1'b1));
    step(mk("to_regrant2",      16'h0004, 1'b0, 1'b1, 4'd2, 1'b0));
    for (int c = 0; c < 3; c++) step(mk("to_hold2", 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0));
    step(mk("to_done_priority", 16'h0004, 1'b1, 1'b0, 4'd0, 1'b0));
`else
    for (int c = 0; c < 8; c++) step(mk("no_to_hold", 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0));
    step(mk("no_to_done", 16'h0004, 1'b1, 1'b0, 4'd0, 1'b0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
